// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// Synchronous FIFO with flush; head entry is visible combinationally while not empty.
module fetch_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so push is allowed at full when popping.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues word-aligned imem requests, buffers in-order responses
// for decode, and drops stale responses after a redirect.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_discard_cnt;
    logic             r_req_hold;

    logic [CNT_W-1:0] w_flight_cnt;
    logic [CNT_W-1:0] w_buf_cnt;
    logic [XLEN-1:0]  w_flight_head;
    logic             w_flight_full;
    logic             w_flight_empty;
    logic             w_buf_full;
    logic             w_buf_empty;
    fetch_entry_t     w_buf_head;
    fetch_entry_t     w_buf_wr;

    logic             w_room;
    logic             w_req_fire;
    logic             w_instr_fire;
    logic             w_rsp_hit;
    logic             w_rsp_keep;
    logic [SUM_W-1:0] w_outstanding;
    logic [SUM_W-1:0] w_discard_next;

    assign w_instr_fire  = instr_valid && instr_ready;
    assign w_outstanding = SUM_W'(w_flight_cnt) + SUM_W'(r_discard_cnt);

    // A decode pop this cycle counts as free space; r_req_hold keeps a request
    // raised on that credit stable until memory accepts it.
    assign w_room = ((SUM_W'(w_flight_cnt) + SUM_W'(w_buf_cnt)) <
                     (SUM_W'(BUF_DEPTH) + SUM_W'(w_instr_fire)))
                    && !w_flight_full && (!w_buf_full || w_instr_fire);

    assign imem_req_valid = !rst && (r_state == FETCH) && (r_req_hold || w_room);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_hit  = imem_rsp_valid && (w_outstanding != '0);
    assign w_rsp_keep = w_rsp_hit && (r_state == FETCH) && !redirect_valid && !w_flight_empty;

    // Everything still owed by memory, including this cycle's acceptance, minus
    // a response consumed this cycle, must be dropped after a redirect.
    assign w_discard_next = w_outstanding + SUM_W'(w_req_fire) - SUM_W'(w_rsp_hit);

    assign w_buf_wr.data = imem_rsp_data;
    assign w_buf_wr.pc   = w_flight_head;

    assign instr_valid = !w_buf_empty;
    assign instruction = instr_valid ? w_buf_head.data : '0;
    assign instr_pc    = instr_valid ? w_buf_head.pc   : '0;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN)
    ) u_flight_q (
        .clk     (clk),
        .rst     (rst),
        .push    (w_req_fire),
        .wr_data (r_pc),
        .pop     (w_rsp_keep),
        .flush   (redirect_valid),
        .rd_data (w_flight_head),
        .full    (w_flight_full),
        .empty   (w_flight_empty),
        .count   (w_flight_cnt)
    );

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_instr_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (w_rsp_keep),
        .wr_data (w_buf_wr),
        .pop     (w_instr_fire),
        .flush   (redirect_valid),
        .rd_data (w_buf_head),
        .full    (w_buf_full),
        .empty   (w_buf_empty),
        .count   (w_buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = (w_discard_next != '0) ? DRAIN : FETCH;
        end else if (r_state == DRAIN) begin
            if ((r_discard_cnt == '0) || (imem_rsp_valid && (r_discard_cnt == CNT_W'(1)))) begin
                w_state_next = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_discard_cnt <= '0;
            r_req_hold    <= 1'b0;
        end else begin
            r_req_hold <= imem_req_valid && !imem_req_ready && !redirect_valid;
            if (redirect_valid) begin
                r_pc          <= align_pc(redirect_pc);
                r_discard_cnt <= CNT_W'(w_discard_next);
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if ((r_state == DRAIN) && imem_rsp_valid && (r_discard_cnt != '0)) begin
                    r_discard_cnt <= r_discard_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory model, delivery scoreboard and monitor.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instruction;
    logic [31:0] w_instr_pc;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          spur = 1'b0;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    int          acc;
    int          n;
    bit          seen;
    logic [31:0] held_pc;
    logic [31:0] held_ins;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (w_instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (w_instruction),
        .instr_pc       (w_instr_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: in-order responses mem_lat cycles after acceptance, data = ~addr.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (rst) begin
                pend.delete();
            end else if (spur) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                spur = 1'b0;
            end else if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~pend[0].addr;
                void'(pend.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready)
            pend.push_back('{imem_req_addr, cyc + mem_lat});
    end

    // Scoreboard monitor: every decode handshake must match the next expected pc.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected got pc=%08h exp=none", instr_pc);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_pc", instr_pc, sb_e);
                check("sb_data", instruction, ~sb_e);
            end
        end
    end

    task automatic do_reset(input logic rdy, input logic irdy, input int lat, input bit chk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = rdy;
        instr_ready    = irdy;
        mem_lat        = lat;
        spur           = 1'b0;
        exp_q.delete();
        tick();
        if (chk) begin
            @(negedge clk);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instruction", instruction, 32'd0);
            check("rst_instr_pc", instr_pc, 32'd0);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        instr_ready = 1'b0;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_req(input int budget);
        n = 0;
        @(negedge clk);
        while (!imem_req_valid && n < budget) begin
            tick();
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        // Streaming fetch with reset checks; second instance checks PC wrap.
        do_reset(1'b1, 1'b1, 1, 1'b1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_req_valid", 32'(imem_req_valid), 32'd1);
            check("t1_req_addr", imem_req_addr, 32'(i * 4));
            if (i == 0) begin
                check("wrap_req_valid", 32'(w_req_valid), 32'd1);
                check("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
                check("wrap_instr_valid", 32'(w_instr_valid), 32'd0);
                check("wrap_instr_pc", w_instr_pc, 32'd0);
                check("wrap_instruction", w_instruction, 32'd0);
            end
            if (i == 1) check("wrap_addr1", w_req_addr, 32'h0000_0000);
            tick();
        end
        wait_drain("t1_drain", 20);

        // Decode stalled: only BUF_DEPTH requests, head held stable.
        do_reset(1'b1, 1'b0, 1, 1'b0);
        acc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc++;
            if (instr_valid) begin
                if (!seen) begin
                    seen     = 1'b1;
                    held_pc  = instr_pc;
                    held_ins = instruction;
                end else begin
                    check("t2_stable_pc", instr_pc, held_pc);
                    check("t2_stable_ins", instruction, held_ins);
                end
            end
            tick();
        end
        check("t2_req_count", 32'(acc), 32'd2);
        check("t2_held_pc", held_pc, 32'h0);
        check("t2_held_ins", held_ins, ~32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        instr_ready = 1'b1;
        wait_drain("t2_drain", 20);

        // Two requests in flight dropped by redirect to 0x200.
        do_reset(1'b0, 1'b1, 4, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        @(negedge clk);
        check("t3_addr0", imem_req_addr, 32'h10);
        tick();
        @(negedge clk);
        check("t3_addr1", imem_req_addr, 32'h14);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("t3_full_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_state_drain", 32'(dut.r_state), 32'(DRAIN));
        check("t3_drain_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        wait_req(20);
        check("t3_refetch_valid", 32'(imem_req_valid), 32'd1);
        check("t3_refetch_addr", imem_req_addr, 32'h200);
        check("t3_state_fetch", 32'(dut.r_state), 32'(FETCH));
        tick();
        wait_drain("t3_drain", 30);

        // Misaligned redirect; same-cycle response and acceptance both discarded.
        do_reset(1'b1, 1'b1, 1, 1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_no_instr", 32'(instr_valid), 32'd0);
        check("t4_state_drain", 32'(dut.r_state), 32'(DRAIN));
        tick();
        wait_req(20);
        check("t4_refetch_valid", 32'(imem_req_valid), 32'd1);
        check("t4_refetch_addr", imem_req_addr, 32'h100);
        tick();
        wait_drain("t4_drain", 30);

        // Redirect coinciding with a decode handshake on a full buffer.
        do_reset(1'b1, 1'b0, 1, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        check("t5_buf_valid", 32'(instr_valid), 32'd1);
        check("t5_buf_head", instr_pc, 32'h0);
        tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_flushed", 32'(instr_valid), 32'd0);
        tick();
        wait_drain("t5_drain", 30);

        // Response with nothing outstanding is ignored.
        do_reset(1'b0, 1'b1, 1, 1'b0);
        spur = 1'b1;
        tick();
        @(negedge clk);
        check("t6_spurious_ignored", 32'(instr_valid), 32'd0);
        tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        imem_req_ready = 1'b1;
        wait_drain("t6_drain", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2; instruction buffer entries and max in-flight plus buffered fetches.
REQ-003 SHALL have one clock and a synchronous, active-high reset; clk and rst are the first two ports.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  response data valid; in order, >=1 cycle after acceptance.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect from execute.
REQ-012 redirect_pc  input  32  new fetch target.
REQ-013 instr_valid  output  1  instruction available to decode.
REQ-014 instr_ready  input  1  decode accepts instruction.
REQ-015 instruction  output  32  raw instruction word for decode.
REQ-016 instr_pc  output  32  address of instruction.

Function
REQ-017 Request accepted when imem_req_valid && imem_req_ready; PC advances by 4 on acceptance, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-018 imem_req_valid SHALL assert only in FETCH with (in_flight + buffered) < BUF_DEPTH; addr/valid held stable until accepted or redirected.
REQ-019 Each accepted request pushes its address into an in-flight address queue; each kept response pops it and writes {data, pc} into the buffer.
REQ-020 Response at cycle N SHALL appear on instruction/instr_pc with instr_valid at cycle N+1 (registered, 1-cycle latency) if buffer was empty.
REQ-021 Transfer to decode on instr_valid && instr_ready; buffer SHALL pop same cycle; simultaneous push and pop allowed at full; order preserved.
REQ-022 instruction/instr_pc SHALL hold stable while instr_valid && !instr_ready.
REQ-023 States: FETCH (normal), DRAIN (discarding stale responses).
REQ-024 On redirect_valid (any state): buffer flushed, instr_valid deasserted next cycle, PC <= {redirect_pc[31:2], 2'b00}, discard_cnt <= in-flight count including a request accepted this same cycle; go DRAIN if that count > 0, else FETCH.
REQ-025 In DRAIN no requests issued; each imem_rsp_valid decrements discard_cnt and data is dropped; at zero -> FETCH next cycle.
REQ-026 Response arriving in the redirect cycle SHALL be discarded (counted in discard_cnt before decrement; net effect dropped, never buffered).
REQ-027 Redirect concurrent with a decode handshake: handshake completes, remaining entries flushed; redirect has priority over all other events.
REQ-028 A request accepted in the redirect cycle uses the old PC and is discarded.
REQ-029 Response with no outstanding request is a protocol error; SHALL be ignored (assertion in bench).

Reset
REQ-030 On rst: PC = RESET_PC, state = FETCH, buffer and in-flight queue empty, discard_cnt = 0, imem_req_valid = 0, instr_valid = 0, instruction = 0, instr_pc = 0.
REQ-031 First request SHALL assert in the cycle after rst deasserts, addr = RESET_PC.
REQ-032 rst mid-operation overrides redirect and all handshakes; responses for pre-reset requests are the memory model's responsibility to suppress.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the state enum (FETCH, DRAIN), XLEN = 32, default RESET_PC and NOP = 32'h0000_0013.
REQ-034 Buffer SHALL be a sub-module fetch_buffer (synchronous FIFO, depth BUF_DEPTH, width 64, push/pop/flush, full/empty/count).
REQ-035 Output instruction feeds the decode stage unchanged; no decoding in this block.

Verification
REQ-036 Reset, imem ready always, 1-cycle latency, instr_ready=1 -> addrs 0x0,0x4,0x8 issued on consecutive cycles; instr_pc 0x0,0x4,0x8 in order.
REQ-037 instr_ready=0 for 10 cycles -> at most 2 requests issued, instruction/instr_pc stable; release -> both delivered in order, no loss.
REQ-038 Two requests in flight (0x10,0x14), redirect_pc=0x200 -> both responses dropped, state DRAIN then FETCH, next instr_pc=0x200.
REQ-039 redirect_pc=0x103 -> fetch address 0x100.
REQ-040 Redirect and instr handshake same cycle with 2 buffered -> one transfer, other flushed, next delivered instr_pc = redirect target.
REQ-041 RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
